// File: rtl/bcd_seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner with a single-entry pending load buffer.
// Latency: an/seg one clock after slot state. Backpressure: load_ready low while pending is full.
// Optional LEADING_ZERO_BLANK_EN: blanks zero digits above the most significant non-zero digit.
module bcd_seg_scan_ctrl #(
    parameter int CLK_DIV = 1000,
    parameter int GUARD   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        load_valid,
    input  logic [15:0] load_data,
    output logic        load_ready,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic [1:0]  digit_idx,
    output logic        frame_done
);

    localparam logic [15:0] TICK_VAL  = 16'(CLK_DIV - 1);
    localparam logic [15:0] GUARD_VAL = 16'(GUARD);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;
    logic        frame_done_q, frame_done_d;
    logic [15:0] disp_q, disp_d;
    logic [15:0] pend_q, pend_d;
    logic        pend_full_q, pend_full_d;

    logic        running;
    logic        tick;
    logic        frame_end;
    logic        lit;
    logic        blank;
    logic        accept;
    logic [3:0]  cur_digit;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b1000000;
        endcase
        return s;
    endfunction

    always_comb begin
        state_d      = enable ? SCAN : IDLE;
        cnt_d        = 16'd0;
        idx_d        = 2'd0;
        an_d         = 4'b0000;
        seg_d        = 7'b0000000;
        disp_d       = disp_q;
        pend_d       = pend_q;
        pend_full_d  = pend_full_q;

        // The edge that leaves SCAN already behaves as idle for counters and outputs.
        running      = (state_q == SCAN) && enable;
        tick         = (cnt_q == TICK_VAL);
        frame_end    = running && tick && (idx_q == 2'd3);
        frame_done_d = frame_end;
        lit          = running && (cnt_q >= GUARD_VAL);
        accept       = load_valid && !pend_full_q;
        cur_digit    = disp_q[{idx_q, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
        case (idx_q)
            2'd3:    blank = (disp_q[15:12] == 4'd0);
            2'd2:    blank = (disp_q[15:8]  == 8'd0);
            2'd1:    blank = (disp_q[15:4]  == 12'd0);
            default: blank = 1'b0;
        endcase
`else
        blank = 1'b0;
`endif

        if (running) begin
            cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
            idx_d = tick ? idx_q + 2'd1 : idx_q;
        end

        if (lit) begin
            an_d  = 4'b0001 << idx_q;
            seg_d = blank ? 7'b0000000 : decode(cur_digit);
        end

        // Display only changes between frames while scanning so a frame never tears.
        if (state_q == IDLE) begin
            if (accept) begin
                disp_d = load_data;
            end else if (pend_full_q) begin
                disp_d      = pend_q;
                pend_full_d = 1'b0;
            end
        end else if (frame_end && pend_full_q) begin
            disp_d      = pend_q;
            pend_full_d = 1'b0;
        end else if (frame_end && accept) begin
            disp_d = load_data;
        end else if (accept) begin
            pend_d      = load_data;
            pend_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 16'd0;
            idx_q        <= 2'd0;
            an_q         <= 4'b0000;
            seg_q        <= 7'b0000000;
            frame_done_q <= 1'b0;
            disp_q       <= 16'h0000;
            pend_q       <= 16'h0000;
            pend_full_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_full_q  <= pend_full_d;
        end
    end

    assign load_ready = !pend_full_q;
    assign seg        = seg_q;
    assign an         = an_q;
    assign digit_idx  = idx_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_seg_scan_ctrl.sv
// Directed bench for bcd_seg_scan_ctrl with CLK_DIV=8, GUARD=2.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_bcd_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        lv = 1'b0;
    logic [15:0] ld = 16'h0000;
    logic        load_ready;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [1:0]  digit_idx;
    logic        frame_done;
    logic [14:0] obs;
    logic [14:0] e;

    int tests = 0;
    int fails = 0;

    // Reference state: m_p is the scan position (cycle within the run) of the state
    // present just before the last edge; -2 means the block sat in IDLE.
    int          m_p    = -2;
    logic [15:0] m_disp = 16'h0000;
    logic [15:0] m_pend = 16'h0000;
    logic        m_full = 1'b0;
    logic        m_acc  = 1'b0;

    bcd_seg_scan_ctrl #(.CLK_DIV(8), .GUARD(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (en),
        .load_valid (lv),
        .load_data  (ld),
        .load_ready (load_ready),
        .seg        (seg),
        .an         (an),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    assign obs = {an, seg, frame_done, digit_idx, load_ready};

    function automatic logic [6:0] dec(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b1000000;
        endcase
        return s;
    endfunction

    function automatic logic [14:0] exp_vec(input int p, input logic [15:0] disp, input logic full);
        logic [3:0] a;
        logic [6:0] s;
        logic       f;
        logic [1:0] ix;
        int         sl;
        a = 4'b0000; s = 7'b0; f = 1'b0; ix = 2'd0; sl = 0;
        if (p >= 0) begin
            sl = (p / 8) % 4;
            if ((p % 8) >= 2) a = 4'(1 << sl);
            f  = ((p % 32) == 31);
            ix = 2'(((p + 1) / 8) % 4);
        end
        if (a != 4'b0000) begin
            s = dec(disp[sl*4 +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
            if (sl > 0 && (disp >> (4 * sl)) == 16'h0000) s = 7'b0;
`endif
        end
        return {a, s, f, ix, !full};
    endfunction

    // Advances one clock, updates the reference and returns the expected output vector.
    task automatic cyc(output logic [14:0] ev);
        logic [15:0] d_old;
        logic        acc;
        logic        bnd;
        d_old = m_disp;
        acc   = lv && !m_full;
        m_acc = acc;
        @(posedge clk);
        if (m_p == -2) begin
            if (acc) m_disp = ld;
            else if (m_full) begin m_disp = m_pend; m_full = 1'b0; end
        end else begin
            bnd = en && (((m_p + 1) % 32) == 31);
            if (bnd && m_full) begin m_disp = m_pend; m_full = 1'b0; end
            else if (bnd && acc) m_disp = ld;
            else if (acc) begin m_pend = ld; m_full = 1'b1; end
        end
        m_p = en ? m_p + 1 : -2;
        @(negedge clk);
        ev = exp_vec(m_p, d_old, m_full);
    endtask

    task automatic test_reset();
        #2;
        tests++;
        if (obs !== 15'b0000_0000000_0_00_1) begin
            fails++;
            $display("FAIL reset_state got %b exp %b", obs, 15'b0000_0000000_0_00_1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            cyc(e);
            tests++;
            if (obs !== e) begin fails++; $display("FAIL idle_after_reset got %b exp %b", obs, e); end
        end
    endtask

    task automatic test_scan_frame();
        en = 1'b1;
        repeat (70) begin
            cyc(e);
            tests++;
            if (obs !== e) begin fails++; $display("FAIL scan p=%0d got %b exp %b", m_p, obs, e); end
        end
    endtask

    task automatic test_load_boundary();
        for (int k = 0; k < 40 && (m_p % 32) != 11; k++) begin
            cyc(e);
            tests++;
            if (obs !== e) begin fails++; $display("FAIL load_pre p=%0d got %b exp %b", m_p, obs, e); end
        end
        lv = 1'b1; ld = 16'h1234;
        cyc(e);
        lv = 1'b0;
        tests++;
        if (load_ready !== 1'b0) begin fails++; $display("FAIL load_ready_drop got %b exp 0", load_ready); end
        for (int k = 0; k < 40 && (m_p % 32) != 15; k++) begin
            cyc(e);
            tests++;
            if (obs !== e) begin fails++; $display("FAIL load_wait p=%0d got %b exp %b", m_p, obs, e); end
        end
        lv = 1'b1; ld = 16'h5678;
        repeat (120) begin
            cyc(e);
            if (m_acc) lv = 1'b0;
            tests++;
            if (obs !== e) begin fails++; $display("FAIL back_to_back p=%0d got %b exp %b", m_p, obs, e); end
        end
    endtask

    task automatic test_dash();
        lv = 1'b1; ld = 16'h00A7;
        cyc(e);
        lv = 1'b0;
        for (int k = 0; k < 70; k++) begin
            cyc(e);
            tests++;
            if (obs !== e) begin fails++; $display("FAIL dash p=%0d got %b exp %b", m_p, obs, e); end
            if (k >= 30 && an == 4'b0010) begin
                tests++;
                if (seg !== 7'b1000000) begin fails++; $display("FAIL dash_digit1 got %b exp 1000000", seg); end
            end
            if (k >= 30 && an == 4'b0001) begin
                tests++;
                if (seg !== 7'b0000111) begin fails++; $display("FAIL dash_digit0 got %b exp 0000111", seg); end
            end
            if (k >= 30 && (an == 4'b0100 || an == 4'b1000)) begin
                tests++;
`ifdef LEADING_ZERO_BLANK_EN
                if (seg !== 7'b0000000) begin fails++; $display("FAIL lead_zero got %b exp 0000000", seg); end
`else
                if (seg !== 7'b0111111) begin fails++; $display("FAIL lead_zero got %b exp 0111111", seg); end
`endif
            end
        end
    endtask

    task automatic test_enable_drop();
        for (int k = 0; k < 40 && (m_p % 32) != 19; k++) begin
            cyc(e);
            tests++;
            if (obs !== e) begin fails++; $display("FAIL drop_pre p=%0d got %b exp %b", m_p, obs, e); end
        end
        en = 1'b0;
        cyc(e);
        tests++;
        if (an !== 4'b0000 || seg !== 7'b0 || digit_idx !== 2'd0) begin
            fails++;
            $display("FAIL drop_dark got an=%b seg=%b idx=%0d exp an=0000 seg=0000000 idx=0", an, seg, digit_idx);
        end
        repeat (3) begin
            cyc(e);
            tests++;
            if (obs !== e) begin fails++; $display("FAIL idle p=%0d got %b exp %b", m_p, obs, e); end
        end
        en = 1'b1;
        repeat (40) begin
            cyc(e);
            tests++;
            if (obs !== e) begin fails++; $display("FAIL reenable p=%0d got %b exp %b", m_p, obs, e); end
        end
        en = 1'b0;
        cyc(e);
        cyc(e);
        lv = 1'b1; ld = 16'h0059;
        cyc(e);
        lv = 1'b0;
        tests++;
        if (load_ready !== 1'b1) begin fails++; $display("FAIL idle_load_ready got %b exp 1", load_ready); end
        en = 1'b1;
        repeat (40) begin
            cyc(e);
            tests++;
            if (obs !== e) begin fails++; $display("FAIL idle_load p=%0d got %b exp %b", m_p, obs, e); end
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 40 && (m_p % 32) != 5; k++) begin
            cyc(e);
            tests++;
            if (obs !== e) begin fails++; $display("FAIL rst_pre p=%0d got %b exp %b", m_p, obs, e); end
        end
        lv = 1'b1; ld = 16'h9999;
        cyc(e);
        lv = 1'b0;
        repeat (3) cyc(e);
        tests++;
        if (load_ready !== 1'b0) begin fails++; $display("FAIL rst_pend_full got %b exp 0", load_ready); end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (obs !== 15'b0000_0000000_0_00_1) begin
            fails++;
            $display("FAIL async_reset got %b exp %b", obs, 15'b0000_0000000_0_00_1);
        end
        m_p = -2; m_disp = 16'h0000; m_pend = 16'h0000; m_full = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (45) begin
            cyc(e);
            tests++;
            if (obs !== e) begin fails++; $display("FAIL after_reset p=%0d got %b exp %b", m_p, obs, e); end
        end
    endtask

    initial begin
        test_reset();
        test_scan_frame();
        test_load_boundary();
        test_dash();
        test_enable_drop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
